// File: rtl/intel_vvp_icon_pkg.sv
// Shared ICON definitions: user/keep sizing used by every ICON stream stage.
package intel_vvp_icon_pkg;

  localparam int VVP_USER_KEEP_BITS = 8;

  // Token streams carry a single user bit; video streams carry one keep bit per lane.
  function automatic int icon_user_width(input int data_w, input int is_token);
    if (is_token != 0) begin
      return 1;
    end else begin
      return (data_w + VVP_USER_KEEP_BITS - 1) / VVP_USER_KEEP_BITS;
    end
  endfunction

endpackage

// File: rtl/intel_vvp_icon_axi_master_buffered_if.sv
// Valid/ready beat bundle used on both sides of the buffered master stage.
interface intel_vvp_icon_axi_master_buffered_if #(
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 3
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;
  logic                  last;
  logic                  ready;

  modport master (output valid, data, user, last, input ready);
  modport slave  (input valid, data, user, last, output ready);
endinterface

// File: rtl/intel_vvp_icon_sc_fifo.sv
// Generic single-clock first-word-fall-through FIFO over a register array.
module intel_vvp_icon_sc_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      occ_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Full/empty come from the occupancy count so pointer equality is never ambiguous.
  assign full      = (occ_r == FULL_OCC);
  assign empty     = (occ_r == '0);
  assign wr_ok_s   = wr_en & ~full;
  assign rd_ok_s   = rd_en & ~empty;
  assign rd_data   = mem_r[rd_ptr_r];
  assign occupancy = occ_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   occ_r <= occ_r + (AW+1)'(1);
        2'b01:   occ_r <= occ_r - (AW+1)'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: rtl/intel_vvp_icon_axi_master_buffered.sv
// Buffered AXI4-Stream master output stage: FIFO decoupling from tready plus
// occupancy, almost-full and completed-packet status.
module intel_vvp_icon_axi_master_buffered
  import intel_vvp_icon_pkg::*;
#(
  parameter int DATA_WIDTH         = 24,
  parameter int IS_TOKEN_INTERFACE = 0,
  parameter int FIFO_DEPTH         = 4,
  parameter int ALMOST_FULL_THRESH = 3,
  parameter int PKT_CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  intel_vvp_icon_axi_master_buffered_if.slave  din,
  intel_vvp_icon_axi_master_buffered_if.master axi_st_dout,
  output logic [$clog2(FIFO_DEPTH):0]     occupancy,
  output logic                            almost_full,
  output logic [PKT_CNT_WIDTH-1:0]        pkt_count,
  input  logic                            pkt_count_clear
);
  localparam int USER_WIDTH = icon_user_width(DATA_WIDTH, IS_TOKEN_INTERFACE);
  localparam int BEAT_W     = DATA_WIDTH + USER_WIDTH + 1;
  localparam int OCC_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] AF_THRESH = OCC_W'(ALMOST_FULL_THRESH);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > FIFO_DEPTH) begin : g_bad_thresh
      $error("ALMOST_FULL_THRESH must lie in 1..FIFO_DEPTH");
    end
  endgenerate

  logic                     push_s;
  logic                     pop_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [BEAT_W-1:0]        head_s;
  logic [OCC_W-1:0]         occ_s;
  logic [OCC_W-1:0]         occ_next_s;
  logic                     inc_s;
  logic [PKT_CNT_WIDTH-1:0] pkt_next_s;
  logic [PKT_CNT_WIDTH-1:0] pkt_count_r;
  logic                     almost_full_r;

  // din.ready only sees registered occupancy and rst, never downstream tready.
  assign din.ready   = ~rst & ~fifo_full_s;
  assign push_s      = din.valid & din.ready;
  assign pop_s       = axi_st_dout.valid & axi_st_dout.ready;

  intel_vvp_icon_sc_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push_s),
    .wr_data   ({din.last, din.user, din.data}),
    .full      (fifo_full_s),
    .rd_en     (pop_s),
    .rd_data   (head_s),
    .empty     (fifo_empty_s),
    .occupancy (occ_s)
  );

  assign axi_st_dout.valid = ~fifo_empty_s;
  assign axi_st_dout.data  = head_s[DATA_WIDTH-1:0];
  assign axi_st_dout.user  = head_s[DATA_WIDTH +: USER_WIDTH];
  assign axi_st_dout.last  = head_s[BEAT_W-1];
  assign occupancy         = occ_s;
  assign almost_full       = almost_full_r;
  assign pkt_count         = pkt_count_r;
  assign inc_s             = pop_s & axi_st_dout.last;

  // Next occupancy, mirrored here so almost_full updates on the same edge.
  always_comb begin
    occ_next_s = occ_s;
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_s + OCC_W'(1);
      2'b01:   occ_next_s = occ_s - OCC_W'(1);
      default: occ_next_s = occ_s;
    endcase
  end

  // Packet counter next value; a clear coinciding with a tlast pop leaves 1.
  always_comb begin
    pkt_next_s = pkt_count_r;
    if (pkt_count_clear) begin
      pkt_next_s = inc_s ? PKT_CNT_WIDTH'(1) : '0;
    end else if (inc_s) begin
      pkt_next_s = pkt_count_r + PKT_CNT_WIDTH'(1);
    end else begin
      pkt_next_s = pkt_count_r;
    end
  end

  // Status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_r <= 1'b0;
      pkt_count_r   <= '0;
    end else begin
      almost_full_r <= (occ_next_s >= AF_THRESH);
      pkt_count_r   <= pkt_next_s;
    end
  end

endmodule

// File: tb/tb_intel_vvp_icon_axi_master_buffered.sv
// Scoreboard bench for the buffered ICON AXI-S master stage.
module tb_intel_vvp_icon_axi_master_buffered;
  import intel_vvp_icon_pkg::*;

  localparam int DW    = 24;
  localparam int UW    = icon_user_width(24, 0);
  localparam int DEPTH = 4;
  localparam int AFT   = 3;
  localparam int PCW   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pkt_count_clear = 1'b0;
  logic [2:0]     occupancy;
  logic           almost_full;
  logic [PCW-1:0] pkt_count;
  logic           rand_rdy = 1'b0;

  always #5 clk = ~clk;

  intel_vvp_icon_axi_master_buffered_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) din_if ();
  intel_vvp_icon_axi_master_buffered_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dout_if ();

  intel_vvp_icon_axi_master_buffered #(
    .DATA_WIDTH(DW), .IS_TOKEN_INTERFACE(0), .FIFO_DEPTH(DEPTH),
    .ALMOST_FULL_THRESH(AFT), .PKT_CNT_WIDTH(PCW)
  ) dut (
    .clk(clk), .rst(rst), .din(din_if), .axi_st_dout(dout_if),
    .occupancy(occupancy), .almost_full(almost_full),
    .pkt_count(pkt_count), .pkt_count_clear(pkt_count_clear)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state, advanced at each falling edge.
  logic [27:0]    sb_q[$];
  int             m_occ = 0;
  logic [PCW-1:0] m_pkt = '0;
  logic           prev_hold = 1'b0;
  logic [27:0]    prev_beat = '0;
  int             n_pops = 0;

  always @(negedge clk) begin : monitor
    logic        push, pop;
    logic [27:0] head, exp_b;
    int          occ_before;
    if (rst) begin
      check_val("rst_tvalid", 32'(dout_if.valid), 32'd0);
      check_val("rst_din_ready", 32'(din_if.ready), 32'd0);
      check_val("rst_occupancy", 32'(occupancy), 32'd0);
      check_val("rst_pkt_count", 32'(pkt_count), 32'd0);
      sb_q.delete();
      m_occ = 0;
      m_pkt = '0;
      prev_hold = 1'b0;
    end else begin
      head = {dout_if.last, dout_if.user, dout_if.data};
      check_val("occupancy", 32'(occupancy), 32'(m_occ));
      check_val("almost_full", 32'(almost_full), 32'(m_occ >= AFT));
      check_val("din_ready", 32'(din_if.ready), 32'(m_occ != DEPTH));
      check_val("tvalid", 32'(dout_if.valid), 32'(m_occ != 0));
      check_val("pkt_count", 32'(pkt_count), 32'(m_pkt));
      if (prev_hold) check_val("dout_stable", 32'(head), 32'(prev_beat));
      push = din_if.valid && (m_occ != DEPTH);
      pop  = dout_if.ready && (m_occ != 0);
      occ_before = m_occ;
      if (pop) begin
        exp_b = sb_q.pop_front();
        check_val("beat", 32'(head), 32'(exp_b));
        n_pops++;
      end
      if (push) sb_q.push_back({din_if.last, din_if.user, din_if.data});
      m_occ = m_occ + int'(push) - int'(pop);
      if (pkt_count_clear) m_pkt = (pop && exp_b[27]) ? PCW'(1) : '0;
      else if (pop && exp_b[27]) m_pkt = m_pkt + PCW'(1);
      prev_hold = (occ_before != 0) && !dout_if.ready;
      prev_beat = head;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      dout_if.ready = 1'($urandom_range(0, 1));
      #1 dout_if.ready = ~dout_if.ready;
      #1 check_val("ready_indep", 32'(din_if.ready), 32'(m_occ != DEPTH));
      dout_if.ready = ~dout_if.ready;
    end
  endtask

  task automatic send_beat(input logic [23:0] d, input logic [2:0] u, input logic l);
    logic acc;
    logic ok;
    din_if.valid = 1'b1;
    din_if.data  = d;
    din_if.user  = u;
    din_if.last  = l;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = din_if.ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    din_if.valid = 1'b0;
    check_val("accept", 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    logic [PCW-1:0] exp_pkt [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1};
    logic           clr_at  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    din_if.valid = 1'b0; din_if.data = '0; din_if.user = '0; din_if.last = 1'b0;
    dout_if.ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // 1: eight beats streaming straight through
    check_val("t1_idle_tvalid", 32'(dout_if.valid), 32'd0);
    dout_if.ready = 1'b1;
    base = n_pops;
    for (int i = 1; i <= 8; i++) begin
      send_beat(24'(i), 3'(i), (i == 8));
      if (i == 1) begin
        check_val("t1_first_tvalid", 32'(dout_if.valid), 32'd1);
        check_val("t1_first_data", 32'(dout_if.data), 32'd1);
      end
    end
    repeat (3) tick();
    check_val("t1_pops", 32'(n_pops - base), 32'd8);
    check_val("t1_pkt_count", 32'(pkt_count), 32'd1);

    // 2: fill against a stalled sink
    dout_if.ready = 1'b0;
    din_if.valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din_if.data = 24'(100 + k); din_if.user = 3'(k); din_if.last = 1'b0;
      tick();
    end
    din_if.valid = 1'b0;
    #1;
    check_val("t2_occ_full", 32'(occupancy), 32'd4);
    check_val("t2_almost_full", 32'(almost_full), 32'd1);
    check_val("t2_head", 32'(dout_if.data), 32'd100);

    // 3: drain from full with continuous push
    dout_if.ready = 1'b1;
    din_if.valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din_if.data = 24'(200 + k); din_if.user = 3'(k); din_if.last = (k == 5);
      tick();
      if (k == 2) check_val("t3_occ_steady", 32'(occupancy), 32'd3);
    end
    din_if.valid = 1'b0;
    repeat (6) tick();

    // 6: wrapping packet counter with clears
    pkt_count_clear = 1'b1;
    tick();
    pkt_count_clear = 1'b0;
    #1 check_val("t6_cleared", 32'(pkt_count), 32'd0);
    for (int i = 0; i < 7; i++) begin
      send_beat(24'(300 + i), 3'd0, 1'b1);
      pkt_count_clear = clr_at[i];
      tick();
      pkt_count_clear = 1'b0;
      #3 check_val("t6_pkt_seq", 32'(pkt_count), 32'(exp_pkt[i]));
    end

    // 4: random valid/ready traffic
    rand_rdy = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      if ($urandom_range(0, 1) == 0) tick();
      send_beat(24'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
    end
    rand_rdy = 1'b0;
    dout_if.ready = 1'b1;
    repeat (8) tick();
    check_val("t4_drained", 32'(occupancy), 32'd0);

    // 5: asynchronous reset with three beats stored
    dout_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(24'(500 + i), 3'd1, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("t5_tvalid", 32'(dout_if.valid), 32'd0);
    check_val("t5_occupancy", 32'(occupancy), 32'd0);
    check_val("t5_pkt_count", 32'(pkt_count), 32'd0);
    check_val("t5_din_ready", 32'(din_if.ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    dout_if.ready = 1'b1;
    base = n_pops;
    send_beat(24'h5A5A5A, 3'b101, 1'b1);
    repeat (3) tick();
    check_val("t5_new_beat_pops", 32'(n_pops - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
